// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle RV32I controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if #(
    parameter int ALUCTRL_W = 3
);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 Zero;
    logic                 LtS;
    logic                 LtU;
    logic                 MemReady;

    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 MemWrite;
    logic                 IRWrite;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic                 RegWrite;
    logic [2:0]           ImmSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 Illegal;
    logic                 InstrDone;

    modport master (
        input  op, funct3, funct7b5, Zero, LtS, LtU, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, Illegal, InstrDone
    );

    modport slave (
        output op, funct3, funct7b5, Zero, LtS, LtU, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, Illegal, InstrDone
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM with one shared memory port, ALU and
// immediate decoders, conditional branch resolution and a sticky illegal-instruction trap.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE   | ALUOut <= OldPC+imm, dispatch on opcode
// MEMADR   | ALUOut <= rs1+imm (load/store address)
// MEMREAD  | load data read, wait for MemReady
// MEMWB    | rd <= load data
// MEMWRITE | store data written when MemReady
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare rs1/rs2, PC <= target if taken
// JAL      | PC <= ALUOut, ALUOut <= OldPC+4
// JALR     | ALUOut <= rs1+imm
// LUI      | ALUOut <= 0+imm
// TRAP     | unsupported encoding, held until reset
module multicycle_controller #(
    parameter int ALUCTRL_W = 3,
    parameter int BR_EXT    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, BRANCH, JAL, JALR, LUI, TRAP
    } state_t;

    typedef struct packed {
        logic       adrsrc;
        logic [1:0] resultsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic       regwrite;
        logic       illegal;
        logic       done;
    } moore_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    state_t state;
    state_t nxt;
    moore_t mo_q;
    moore_t mo;
    logic   alu_ok;
    logic   br_ok;
    logic   taken;

    function automatic moore_t moore_of(state_t s);
        moore_t m;
        m = '0;
        case (s)
            FETCH:    begin m.srcb = 2'b10; m.resultsrc = 2'b10; end
            DECODE:   begin m.srca = 2'b01; m.srcb = 2'b01; end
            MEMADR:   begin m.srca = 2'b10; m.srcb = 2'b01; end
            MEMREAD:  m.adrsrc = 1'b1;
            MEMWB:    begin m.resultsrc = 2'b01; m.regwrite = 1'b1; m.done = 1'b1; end
            MEMWRITE: m.adrsrc = 1'b1;
            EXECR:    begin m.srca = 2'b10; m.srcb = 2'b00; m.aluop = 2'b10; end
            EXECI:    begin m.srca = 2'b10; m.srcb = 2'b01; m.aluop = 2'b10; end
            ALUWB:    begin m.regwrite = 1'b1; m.done = 1'b1; end
            BRANCH:   begin m.srca = 2'b10; m.srcb = 2'b00; m.aluop = 2'b01; m.done = 1'b1; end
            JAL:      begin m.srca = 2'b01; m.srcb = 2'b10; end
            JALR:     begin m.srca = 2'b10; m.srcb = 2'b01; end
            LUI:      begin m.srca = 2'b11; m.srcb = 2'b01; end
            TRAP:     m.illegal = 1'b1;
            default:  m = '0;
        endcase
        return m;
    endfunction

    // A 3-bit ALU only implements add/sub/and/or/slt; anything else must trap in DECODE.
    assign alu_ok = (ALUCTRL_W >= 4) || (bus.funct3 == 3'b000) || (bus.funct3 == 3'b010)
                    || (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
    assign br_ok  = (bus.funct3 != 3'b010) && (bus.funct3 != 3'b011)
                    && ((BR_EXT != 0) || (bus.funct3 == 3'b000));

    always_comb begin
        taken = 1'b0;
        case (bus.funct3)
            3'b000:  taken = bus.Zero;
            3'b001:  taken = ~bus.Zero;
            3'b100:  taken = bus.LtS;
            3'b101:  taken = ~bus.LtS;
            3'b110:  taken = bus.LtU;
            3'b111:  taken = ~bus.LtU;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            FETCH:    if (bus.MemReady) nxt = DECODE;
            DECODE: begin
                case (bus.op)
                    7'b0000011, 7'b0100011: nxt = MEMADR;
                    7'b0110011: nxt = alu_ok ? EXECR : TRAP;
                    7'b0010011: nxt = alu_ok ? EXECI : TRAP;
                    7'b1100011: nxt = br_ok ? BRANCH : TRAP;
                    7'b1101111: nxt = JAL;
                    7'b1100111: nxt = JALR;
                    7'b0110111: nxt = LUI;
                    7'b0010111: nxt = ALUWB;
                    default:    nxt = TRAP;
                endcase
            end
            MEMADR:   nxt = bus.op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (bus.MemReady) nxt = MEMWB;
            MEMWB:    nxt = FETCH;
            MEMWRITE: if (bus.MemReady) nxt = FETCH;
            EXECR:    nxt = ALUWB;
            EXECI:    nxt = ALUWB;
            ALUWB:    nxt = FETCH;
            BRANCH:   nxt = FETCH;
            JAL:      nxt = ALUWB;
            JALR:     nxt = JAL;
            LUI:      nxt = ALUWB;
            TRAP:     nxt = TRAP;
            default:  nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            mo_q  <= moore_of(FETCH);
        end else begin
            state <= nxt;
            mo_q  <= moore_of(nxt);
        end
    end

    // Reset overrides the registered outputs immediately so a mid-instruction reset writes nothing.
    assign mo = reset ? moore_of(FETCH) : mo_q;

    assign bus.AdrSrc    = mo.adrsrc;
    assign bus.ResultSrc = mo.resultsrc;
    assign bus.ALUSrcA   = mo.srca;
    assign bus.ALUSrcB   = mo.srcb;
    assign bus.RegWrite  = mo.regwrite;
    assign bus.Illegal   = mo.illegal;
    assign bus.IRWrite   = ~reset & (state == FETCH) & bus.MemReady;
    assign bus.MemWrite  = ~reset & (state == MEMWRITE) & bus.MemReady;
    assign bus.PCWrite   = ~reset & (((state == FETCH) & bus.MemReady) | (state == JAL)
                                     | ((state == BRANCH) & taken));
    assign bus.InstrDone = mo.done | (~reset & (state == MEMWRITE) & bus.MemReady);

    always_comb begin
        bus.ImmSrc = 3'b000;
        case (bus.op)
            7'b0100011:             bus.ImmSrc = 3'b001;
            7'b1100011:             bus.ImmSrc = 3'b010;
            7'b1101111:             bus.ImmSrc = 3'b011;
            7'b0110111, 7'b0010111: bus.ImmSrc = 3'b100;
            default:                bus.ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        bus.ALUControl = ALUCTRL_W'(ALU_ADD);
        case (mo.aluop)
            2'b01: bus.ALUControl = ALUCTRL_W'(ALU_SUB);
            2'b10: begin
                case (bus.funct3)
                    3'b000:  bus.ALUControl = (bus.op[5] & bus.funct7b5) ? ALUCTRL_W'(ALU_SUB)
                                                                         : ALUCTRL_W'(ALU_ADD);
                    3'b001:  bus.ALUControl = ALUCTRL_W'(ALU_SLL);
                    3'b010:  bus.ALUControl = ALUCTRL_W'(ALU_SLT);
                    3'b011:  bus.ALUControl = ALUCTRL_W'(ALU_SLTU);
                    3'b100:  bus.ALUControl = ALUCTRL_W'(ALU_XOR);
                    3'b101:  bus.ALUControl = bus.funct7b5 ? ALUCTRL_W'(ALU_SRA)
                                                           : ALUCTRL_W'(ALU_SRL);
                    3'b110:  bus.ALUControl = ALUCTRL_W'(ALU_OR);
                    default: bus.ALUControl = ALUCTRL_W'(ALU_AND);
                endcase
            end
            default: bus.ALUControl = ALUCTRL_W'(ALU_ADD);
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: builds the expected per-cycle control vector of each instruction
// from its class, wait states and flags, then replays it against the controller.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if #(.ALUCTRL_W(3)) bus();
    multicycle_controller #(.ALUCTRL_W(3), .BR_EXT(1)) dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR = 3'd3, A_SLT = 3'd5;
    // vector bits: pcw adr mw irw rs[2] a[2] b[2] rw alu[3] ill done
    localparam logic [15:0] M_EN = 16'hB023, M_ADR = 16'h4000, M_RS = 16'h0C00;
    localparam logic [15:0] M_AB = 16'h03C0, M_ALU = 16'h001C, M_ALL = 16'hFFFF;

    typedef struct {
        bit          rst;
        bit          mr;
        logic [6:0]  op;
        logic [2:0]  f3;
        bit          f7, z, lts, ltu;
        logic [15:0] e, m;
    } step_t;

    step_t      q[$];
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    bit         cur_f7, cur_z, cur_lts, cur_ltu;
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic check_eq(string tag, logic [15:0] obs, logic [15:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [15:0] v(bit pcw, bit adr, bit mw, bit irw, logic [1:0] rs,
                                      logic [1:0] a, logic [1:0] b, bit rw, logic [2:0] alu,
                                      bit ill, bit done);
        return {pcw, adr, mw, irw, rs, a, b, rw, alu, ill, done};
    endfunction

    function automatic bit rmr();
        return 1'($urandom_range(0, 1));
    endfunction

    // {legal, code} for an ALU-class instruction on a 3-bit ALU.
    function automatic logic [3:0] alu_model(logic [6:0] op, logic [2:0] f3, bit f7);
        case (f3)
            3'b000:  return {1'b1, (op[5] && f7) ? A_SUB : A_ADD};
            3'b010:  return {1'b1, A_SLT};
            3'b110:  return {1'b1, A_OR};
            3'b111:  return {1'b1, A_AND};
            default: return 4'b0000;
        endcase
    endfunction

    function automatic bit br_taken(logic [2:0] f3, bit z, bit lts, bit ltu);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return lts;
            3'b101:  return !lts;
            3'b110:  return ltu;
            default: return !ltu;
        endcase
    endfunction

    function automatic logic [3:0] imm_model(logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: return 4'b1000;
            7'b0100011:             return 4'b1001;
            7'b1100011:             return 4'b1010;
            7'b1101111:             return 4'b1011;
            7'b0110111, 7'b0010111: return 4'b1100;
            default:                return 4'b0000;
        endcase
    endfunction

    task automatic push(bit rst, bit mr, logic [15:0] e, logic [15:0] m);
        step_t s;
        s.rst = rst; s.mr = mr; s.op = cur_op; s.f3 = cur_f3; s.f7 = cur_f7;
        s.z = cur_z; s.lts = cur_lts; s.ltu = cur_ltu; s.e = e; s.m = m;
        q.push_back(s);
    endtask

    task automatic reset_steps(int n);
        repeat (n) push(1'b1, rmr(), v(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, A_ADD, 0, 0), M_ALL);
    endtask

    task automatic trap_steps(int n);
        repeat (n) push(1'b0, rmr(), v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, A_ADD, 1, 0), M_EN);
        reset_steps(1 + $urandom_range(0, 1));
    endtask

    task automatic writeback();
        push(1'b0, rmr(), v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, A_ADD, 0, 1), M_EN | M_RS);
    endtask

    task automatic jal_step();
        push(1'b0, rmr(), v(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, A_ADD, 0, 0), M_EN | M_AB | M_ALU | M_RS);
    endtask

    // Fetch/decode prefix, then the class-specific tail; rst_mem aborts a store in its write cycle.
    task automatic add_instr(logic [6:0] op, logic [2:0] f3, bit f7, bit z, bit lts, bit ltu,
                             int wf, int wm, int ntrap, bit rst_mem = 1'b0);
        logic [3:0] am;
        cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z; cur_lts = lts; cur_ltu = ltu;
        repeat (wf) push(1'b0, 1'b0, v(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, A_ADD, 0, 0), M_ALL);
        push(1'b0, 1'b1, v(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, A_ADD, 0, 0), M_ALL);
        push(1'b0, rmr(), v(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, A_ADD, 0, 0), M_EN | M_AB | M_ALU);
        am = alu_model(op, f3, f7);
        case (op)
            7'b0000011, 7'b0100011: begin
                push(1'b0, rmr(), v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, A_ADD, 0, 0), M_EN | M_AB | M_ALU);
                repeat (wm) push(1'b0, 1'b0, v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, A_ADD, 0, 0),
                                 M_EN | M_ADR | M_RS);
                if (op[5] && rst_mem) reset_steps(1);
                else if (op[5])
                    push(1'b0, 1'b1, v(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, A_ADD, 0, 1), M_EN | M_ADR | M_RS);
                else begin
                    push(1'b0, 1'b1, v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, A_ADD, 0, 0), M_EN | M_ADR | M_RS);
                    push(1'b0, rmr(), v(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, A_ADD, 0, 1), M_EN | M_RS);
                end
            end
            7'b0110011, 7'b0010011: begin
                if (am[3]) begin
                    push(1'b0, rmr(), v(0, 0, 0, 0, 2'b00, 2'b10, op[5] ? 2'b00 : 2'b01, 0, am[2:0], 0, 0),
                         M_EN | M_AB | M_ALU);
                    writeback();
                end else trap_steps(ntrap);
            end
            7'b1100011: begin
                if (f3 == 3'b010 || f3 == 3'b011) trap_steps(ntrap);
                else push(1'b0, rmr(), v(br_taken(f3, z, lts, ltu), 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, A_SUB, 0, 1),
                          M_EN | M_AB | M_ALU | M_RS);
            end
            7'b1101111: begin jal_step(); writeback(); end
            7'b1100111: begin
                push(1'b0, rmr(), v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, A_ADD, 0, 0), M_EN | M_AB | M_ALU);
                jal_step();
                writeback();
            end
            7'b0110111: begin
                push(1'b0, rmr(), v(0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 0, A_ADD, 0, 0), M_EN | M_AB | M_ALU);
                writeback();
            end
            7'b0010111: writeback();
            default:    trap_steps(ntrap);
        endcase
    endtask

    task automatic run_queue();
        step_t       s;
        logic [15:0] obs;
        logic [3:0]  im;
        int          idx = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            reset = s.rst; bus.MemReady = s.mr; bus.op = s.op; bus.funct3 = s.f3;
            bus.funct7b5 = s.f7; bus.Zero = s.z; bus.LtS = s.lts; bus.LtU = s.ltu;
            @(negedge clk);
            obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
                   bus.ALUSrcB, bus.RegWrite, bus.ALUControl, bus.Illegal, bus.InstrDone};
            check_eq($sformatf("ctl step %0d op %b", idx, s.op), obs & s.m, s.e & s.m);
            im = imm_model(s.op);
            if (im[3]) check_eq($sformatf("imm step %0d", idx), {13'd0, bus.ImmSrc}, {13'd0, im[2:0]});
            @(posedge clk);
            #1;
            idx++;
        end
    endtask

    logic [6:0] ops[9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [6:0] bad[4] = '{7'b0000000, 7'b1110011, 7'b0001111, 7'b1111111};
    logic [2:0] lg[4]  = '{3'b000, 3'b010, 3'b110, 3'b111};

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        int         k;
        reset = 1'b1; bus.MemReady = 1'b0; bus.op = 7'd0; bus.funct3 = 3'd0;
        bus.funct7b5 = 1'b0; bus.Zero = 1'b0; bus.LtS = 1'b0; bus.LtU = 1'b0;
        @(posedge clk);
        #1;

        cur_op = 7'd0; cur_f3 = 3'd0; cur_f7 = 1'b0; cur_z = 1'b0; cur_lts = 1'b0; cur_ltu = 1'b0;
        reset_steps(2);
        add_instr(7'b0110011, 3'b000, 1'b0, 0, 0, 0, 0, 0, 0);     // add, 4 cycles
        add_instr(7'b0000011, 3'b010, 1'b0, 0, 0, 0, 3, 2, 0);     // lw with wait states, 10 cycles
        add_instr(7'b1100011, 3'b001, 1'b0, 1, 0, 0, 0, 0, 0);     // bne not taken
        add_instr(7'b1100011, 3'b001, 1'b0, 0, 0, 0, 0, 0, 0);     // bne taken
        add_instr(7'b1100011, 3'b110, 1'b0, 0, 0, 1, 0, 0, 0);     // bltu taken
        add_instr(7'b1100011, 3'b111, 1'b0, 0, 0, 1, 0, 0, 0);     // bgeu not taken
        add_instr(7'b1100111, 3'b000, 1'b0, 0, 0, 0, 0, 0, 0);     // jalr
        add_instr(7'b0000000, 3'b000, 1'b0, 0, 0, 0, 0, 0, 20);    // bad opcode
        add_instr(7'b0110011, 3'b100, 1'b0, 0, 0, 0, 0, 0, 20);    // xor on 3-bit ALU
        add_instr(7'b0110011, 3'b000, 1'b1, 0, 0, 0, 1, 0, 0);     // sub
        add_instr(7'b0100011, 3'b010, 1'b0, 0, 0, 0, 0, 0, 0, 1'b1); // sw aborted by reset
        add_instr(7'b0100011, 3'b010, 1'b0, 0, 0, 0, 2, 3, 0);     // sw with waits
        add_instr(7'b1100011, 3'b010, 1'b0, 0, 0, 0, 0, 0, 3);     // funct3 010 branch traps
        run_queue();

        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 10);
            op = (k == 10) ? bad[$urandom_range(0, 3)] : ops[(k == 9) ? 2 : k];
            f3 = 3'($urandom_range(0, 7));
            if ((op == 7'b0110011 || op == 7'b0010011) && $urandom_range(0, 3) != 0)
                f3 = lg[$urandom_range(0, 3)];
            add_instr(op, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 4));
            run_queue();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
